// File: rtl/gb_lcd_pkg.sv
// Shared definitions for the Game Boy LCD stream transmitter: frame timing
// constants, mode and shade encodings, and the internal state type.
package gb_lcd_pkg;

    localparam int unsigned GB_DOTS_PER_LINE  = 456;
    localparam int unsigned GB_OAM_DOTS       = 80;
    localparam int unsigned GB_DRAW_MAX       = 289;
    localparam int unsigned GB_WIDTH          = 160;
    localparam int unsigned GB_VISIBLE_LINES  = 144;
    localparam int unsigned GB_TOTAL_LINES    = 154;

    typedef enum logic [1:0] {
        MODE_HBLANK = 2'd0,
        MODE_VBLANK = 2'd1,
        MODE_OAM    = 2'd2,
        MODE_DRAW   = 2'd3
    } lcd_mode_e;

    typedef enum logic [1:0] {
        SHADE_WHITE = 2'd0,
        SHADE_LIGHT = 2'd1,
        SHADE_DARK  = 2'd2,
        SHADE_BLACK = 2'd3
    } shade_e;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_OAM,
        ST_DRAW,
        ST_HBLANK,
        ST_VBLANK
    } lcd_state_e;

    // OFF reports as HBLANK so that mode reads 0 while the LCD is disabled.
    function automatic lcd_mode_e state_mode(input lcd_state_e s);
        case (s)
            ST_OAM:    return MODE_OAM;
            ST_DRAW:   return MODE_DRAW;
            ST_VBLANK: return MODE_VBLANK;
            default:   return MODE_HBLANK;
        endcase
    endfunction

endpackage

// File: rtl/gb_lcd_timing.sv
// Dot/line counters for the LCD frame plus the vsync, line_start and
// LYC-compare decodes derived from them.
module gb_lcd_timing
    import gb_lcd_pkg::*;
#(
    parameter int unsigned DOTS_PER_LINE = GB_DOTS_PER_LINE,
    parameter int unsigned VISIBLE_LINES = GB_VISIBLE_LINES,
    parameter int unsigned TOTAL_LINES   = GB_TOTAL_LINES
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       run_i,
    input  logic [7:0] lyc_i,
    output logic [8:0] dot_o,
    output logic [7:0] line_o,
    output logic       line_end_o,
    output logic       line_start_o,
    output logic       vsync_o,
    output logic       lyc_match_o
);

    localparam logic [8:0] DOT_LAST  = 9'(DOTS_PER_LINE - 1);
    localparam logic [7:0] LINE_LAST = 8'(TOTAL_LINES - 1);
    localparam logic [7:0] LINE_VIS  = 8'(VISIBLE_LINES);

    logic [8:0] dot_q,  dot_d;
    logic [7:0] line_q, line_d;
    logic       vsync_q, vsync_d;

    always_comb begin
        dot_d  = dot_q;
        line_d = line_q;
        if (clear_i) begin
            dot_d  = '0;
            line_d = '0;
        end else if (run_i) begin
            if (dot_q == DOT_LAST) begin
                dot_d  = '0;
                line_d = (line_q == LINE_LAST) ? '0 : line_q + 8'd1;
            end else begin
                dot_d = dot_q + 9'd1;
            end
        end
        // Registered from the next line so vsync rises on the same edge as LY=144.
        vsync_d = (line_d >= LINE_VIS);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dot_q   <= '0;
            line_q  <= '0;
            vsync_q <= 1'b0;
        end else begin
            dot_q   <= dot_d;
            line_q  <= line_d;
            vsync_q <= vsync_d;
        end
    end

    assign dot_o        = dot_q;
    assign line_o       = line_q;
    assign vsync_o      = vsync_q;
    assign line_end_o   = run_i && (dot_q == DOT_LAST);
    assign line_start_o = run_i && (dot_q == '0) && (line_q < LINE_VIS);
    assign lyc_match_o  = run_i && (line_q == lyc_i);

endmodule

// File: rtl/gb_lcd_stream_tx.sv
// Game Boy LCD pixel-stream transmitter: mode state machine, pixel handshake
// and registered write stream toward the video converter.
module gb_lcd_stream_tx
    import gb_lcd_pkg::*;
#(
    parameter int unsigned DOTS_PER_LINE = GB_DOTS_PER_LINE,
    parameter int unsigned OAM_DOTS      = GB_OAM_DOTS,
    parameter int unsigned DRAW_MAX      = GB_DRAW_MAX,
    parameter int unsigned WIDTH         = GB_WIDTH,
    parameter int unsigned VISIBLE_LINES = GB_VISIBLE_LINES,
    parameter int unsigned TOTAL_LINES   = GB_TOTAL_LINES
) (
    input  logic       clock,
    input  logic       reset_b,
    input  logic       lcd_enable,
    input  logic [7:0] lyc,
    input  logic       pix_valid,
    input  logic [1:0] pix_data,
    output logic       pix_ready,
    output logic       line_start,
    output logic [1:0] pixel_data,
    output logic [7:0] gb_pixel_count,
    output logic [7:0] gb_line_count,
    output logic       gb_hsync,
    output logic       gb_vsync,
    output logic       gb_we,
    output logic [1:0] mode,
    output logic       lyc_match,
    output logic       underrun
);

    localparam logic [8:0] OAM_LAST  = 9'(OAM_DOTS - 1);
    localparam logic [8:0] DRAW_LAST = 9'(DRAW_MAX - 1);
    localparam logic [7:0] X_END     = 8'(WIDTH);
    localparam logic [7:0] X_LAST    = 8'(WIDTH - 1);
    localparam logic [7:0] VIS_LAST  = 8'(VISIBLE_LINES - 1);
    localparam logic [7:0] LINE_LAST = 8'(TOTAL_LINES - 1);

    lcd_state_e state_q, state_d;
    lcd_mode_e  mode_q,  mode_d;
    logic [7:0] x_q, x_d;
    logic [8:0] draw_cnt_q, draw_cnt_d;
    logic [1:0] pdata_q, pdata_d;
    logic [7:0] pcount_q, pcount_d;
    logic       we_q, we_d;
    logic       hsync_q, hsync_d;
    logic       underrun_q, underrun_d;

    logic [8:0] dot;
    logic [7:0] line;
    logic       line_end;
    logic       handshake;

    gb_lcd_timing #(
        .DOTS_PER_LINE (DOTS_PER_LINE),
        .VISIBLE_LINES (VISIBLE_LINES),
        .TOTAL_LINES   (TOTAL_LINES)
    ) u_timing (
        .clk_i        (clock),
        .rst_ni       (reset_b),
        .clear_i      (!lcd_enable),
        .run_i        (state_q != ST_OFF),
        .lyc_i        (lyc),
        .dot_o        (dot),
        .line_o       (line),
        .line_end_o   (line_end),
        .line_start_o (line_start),
        .vsync_o      (gb_vsync),
        .lyc_match_o  (lyc_match)
    );

    assign pix_ready = (state_q == ST_DRAW) && (x_q < X_END);
    assign handshake = pix_ready && pix_valid;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        draw_cnt_d = draw_cnt_q;
        pdata_d    = pdata_q;
        pcount_d   = pcount_q;
        we_d       = 1'b0;
        underrun_d = underrun_q;

        if (!lcd_enable) begin
            state_d    = ST_OFF;
            x_d        = '0;
            draw_cnt_d = '0;
            pdata_d    = '0;
            pcount_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: state_d = ST_OAM;
                ST_OAM: begin
                    if (dot == OAM_LAST) begin
                        state_d    = ST_DRAW;
                        x_d        = '0;
                        draw_cnt_d = '0;
                    end
                end
                ST_DRAW: begin
                    draw_cnt_d = draw_cnt_q + 9'd1;
                    if (handshake) begin
                        we_d     = 1'b1;
                        pdata_d  = pix_data;
                        pcount_d = x_q;
                        x_d      = x_q + 8'd1;
                    end
                    // A final pixel landing on the last allowed dot wins over the abort.
                    if (handshake && (x_q == X_LAST)) begin
                        state_d = ST_HBLANK;
                    end else if (draw_cnt_q == DRAW_LAST) begin
                        state_d    = ST_HBLANK;
                        underrun_d = 1'b1;
                    end
                end
                ST_HBLANK: begin
                    if (line_end) begin
                        state_d = (line < VIS_LAST) ? ST_OAM : ST_VBLANK;
                    end
                end
                ST_VBLANK: begin
                    if (line_end && (line == LINE_LAST)) begin
                        state_d = ST_OAM;
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end

        hsync_d = (state_d == ST_HBLANK);
        mode_d  = state_mode(state_d);
    end

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state_q    <= ST_OFF;
            mode_q     <= MODE_HBLANK;
            x_q        <= '0;
            draw_cnt_q <= '0;
            pdata_q    <= '0;
            pcount_q   <= '0;
            we_q       <= 1'b0;
            hsync_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            x_q        <= x_d;
            draw_cnt_q <= draw_cnt_d;
            pdata_q    <= pdata_d;
            pcount_q   <= pcount_d;
            we_q       <= we_d;
            hsync_q    <= hsync_d;
            underrun_q <= underrun_d;
        end
    end

    assign pixel_data     = pdata_q;
    assign gb_pixel_count = pcount_q;
    assign gb_line_count  = line;
    assign gb_hsync       = hsync_q;
    assign gb_we          = we_q;
    assign mode           = mode_q;
    assign underrun       = underrun_q;

endmodule

// File: tb/tb_gb_lcd_stream_tx.sv
// Randomized scoreboard bench for gb_lcd_stream_tx against a dot/line
// arithmetic model of the LCD frame.
module tb_gb_lcd_stream_tx;

    logic       clock = 1'b0;
    logic       reset_b;
    logic       lcd_enable;
    logic [7:0] lyc;
    logic       pix_valid;
    logic [1:0] pix_data;
    logic       pix_ready;
    logic       line_start;
    logic [1:0] pixel_data;
    logic [7:0] gb_pixel_count;
    logic [7:0] gb_line_count;
    logic       gb_hsync;
    logic       gb_vsync;
    logic       gb_we;
    logic [1:0] mode;
    logic       lyc_match;
    logic       underrun;

    gb_lcd_stream_tx #(
        .DOTS_PER_LINE (456),
        .OAM_DOTS      (80),
        .DRAW_MAX      (289),
        .WIDTH         (160),
        .VISIBLE_LINES (144),
        .TOTAL_LINES   (154)
    ) dut (
        .clock          (clock),
        .reset_b        (reset_b),
        .lcd_enable     (lcd_enable),
        .lyc            (lyc),
        .pix_valid      (pix_valid),
        .pix_data       (pix_data),
        .pix_ready      (pix_ready),
        .line_start     (line_start),
        .pixel_data     (pixel_data),
        .gb_pixel_count (gb_pixel_count),
        .gb_line_count  (gb_line_count),
        .gb_hsync       (gb_hsync),
        .gb_vsync       (gb_vsync),
        .gb_we          (gb_we),
        .mode           (mode),
        .lyc_match      (lyc_match),
        .underrun       (underrun)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         x;
        logic [1:0] d;
        int         line;
    } wr_t;

    wr_t sb[$];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Model state: t counts dots since the LCD left OFF.
    int   t, mx, hb;
    bit   ur, idle;
    int   exp_writes = 0, writes_seen = 0;
    int   vs_rises = 0, lyc_hi = 0;
    logic prev_vsync = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (time %0t, model dot %0d)",
                     name, act, exp, $time, t);
        end
    endtask

    task automatic check_quiet(input string tag, input bit exp_ur);
        check({tag, "_mode"},       mode, 0);
        check({tag, "_we"},         gb_we, 0);
        check({tag, "_hsync"},      gb_hsync, 0);
        check({tag, "_vsync"},      gb_vsync, 0);
        check({tag, "_line"},       gb_line_count, 0);
        check({tag, "_pcount"},     gb_pixel_count, 0);
        check({tag, "_pdata"},      pixel_data, 0);
        check({tag, "_line_start"}, line_start, 0);
        check({tag, "_lyc_match"},  lyc_match, 0);
        check({tag, "_pix_ready"},  pix_ready, 0);
        check({tag, "_underrun"},   underrun, exp_ur);
    endtask

    task automatic step();
        int         dot, line, m;
        bit         v;
        logic [1:0] d;
        dot  = t % 456;
        line = (t / 456) % 154;
        if (dot == 0) begin
            mx = 0;
            hb = 80 + 289;
        end
        if (line >= 144)   m = 1;
        else if (dot < 80) m = 2;
        else if (dot < hb) m = 3;
        else               m = 0;

        check("mode",       mode, m);
        check("line_count", gb_line_count, line);
        check("vsync",      gb_vsync, line >= 144);
        check("hsync",      gb_hsync, m == 0);
        check("line_start", line_start, dot == 0 && line < 144);
        check("lyc_match",  lyc_match, line == int'(lyc));
        check("pix_ready",  pix_ready, m == 3);
        check("underrun",   underrun, ur);

        if (gb_vsync && !prev_vsync) vs_rises++;
        prev_vsync = gb_vsync;
        if (lyc_match) lyc_hi++;

        d = 2'($urandom);
        if (idle)           v = 1'b0;
        else if (line == 10) v = (mx < 100);
        else if (line == 0)  v = 1'b1;
        else                 v = ($urandom_range(7, 0) != 0);
        pix_valid = v;
        pix_data  = d;

        if (v && m == 3) begin
            sb.push_back('{mx, d, line});
            mx++;
            exp_writes++;
            if (mx == 160) hb = dot + 1;
        end
        if (m == 3 && dot == 368 && mx < 160) ur = 1'b1;
        t++;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            step();
            @(negedge clock);
        end
    endtask

    always @(negedge clock) begin
        if (gb_we === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_write", gb_we, 0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                writes_seen++;
                check("pixel_data",  pixel_data, e.d);
                check("pixel_count", gb_pixel_count, e.x);
                check("write_line",  gb_line_count, e.line);
            end
        end
    end

    initial begin
        int frame_writes;
        reset_b    = 1'b0;
        lcd_enable = 1'b1;
        pix_valid  = 1'b0;
        pix_data   = '0;
        lyc        = 8'd90;
        t = 0; mx = 0; hb = 369; ur = 1'b0; idle = 1'b0;

        repeat (3) @(negedge clock);
        check_quiet("reset", 1'b0);

        reset_b = 1'b1;
        @(negedge clock);
        t = 0;
        run(70224);
        frame_writes = exp_writes;
        check("frame_writes", writes_seen, frame_writes);
        check("vsync_rises",  vs_rises, 1);
        check("lyc_cycles",   lyc_hi, 456);

        run(2 * 456 + 150);
        idle = 1'b1;
        run(1);
        lcd_enable = 1'b0;
        @(negedge clock);
        repeat (4) begin
            check_quiet("lcd_off", ur);
            @(negedge clock);
        end

        lcd_enable = 1'b1;
        lyc  = 8'd3;
        idle = 1'b0;
        @(negedge clock);
        t = 0;
        run(5 * 456 + 200);
        idle = 1'b1;
        run(1);
        check("queue_drained", sb.size(), 0);
        #2 reset_b = 1'b0;
        #1 check_quiet("async_reset", 1'b0);

        @(negedge clock);
        reset_b = 1'b1;
        @(negedge clock);
        t = 0; ur = 1'b0; idle = 1'b0;
        run(600);
        idle = 1'b1;
        run(2);
        check("queue_empty",  sb.size(), 0);
        check("total_writes", writes_seen, exp_writes);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
